// File: rtl/seg_scan_capture.sv
// seg_scan_capture: passive read-back monitor for a multiplexed 4-digit
// seven-segment bus. Each stable seg/an pattern is qualified, decoded to a
// hex nibble and kept in one capture slot per digit.

// One capture slot: raw pattern, last good nibble and glyph-valid flag.
module seg_scan_slot (
    input  logic       clk,
    input  logic       arst,
    input  logic       cap,
    input  logic       clr_valid,
    input  logic [6:0] seg,
    output logic [6:0] raw,
    output logic [3:0] nib,
    output logic       dvalid
);

    logic       hit;
    logic [3:0] val;

    // Active-low glyph decode, bit 6 = segment a ... bit 0 = segment g
    always_comb begin
        hit = 1'b1;
        val = 4'h0;
        case (seg)
            7'b0000001: val = 4'h0;
            7'b1001111: val = 4'h1;
            7'b0010010: val = 4'h2;
            7'b0000110: val = 4'h3;
            7'b1001100: val = 4'h4;
            7'b0100100: val = 4'h5;
            7'b0100000: val = 4'h6;
            7'b0001111: val = 4'h7;
            7'b0000000: val = 4'h8;
            7'b0000100: val = 4'h9;
            7'b0001000: val = 4'hA;
            7'b1100000: val = 4'hB;
            7'b0110001: val = 4'hC;
            7'b1000010: val = 4'hD;
            7'b0110000: val = 4'hE;
            7'b0111000: val = 4'hF;
            default:    hit = 1'b0;
        endcase
    end

    // Capture wins over the stale clear; a non-glyph keeps the old nibble
    always_ff @(posedge clk) begin
        if (arst) begin
            raw    <= 7'h7F;
            nib    <= 4'h0;
            dvalid <= 1'b0;
        end else if (cap) begin
            raw    <= seg;
            dvalid <= hit;
            if (hit) nib <= val;
        end else if (clr_valid) begin
            dvalid <= 1'b0;
        end
    end

endmodule

module seg_scan_capture #(
    parameter int SETTLE = 4,
    parameter int STALE  = 50_000_000,
    parameter int TW     = 26
) (
    input  logic        CLK1,
    input  logic        arst,
    input  logic [0:6]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] digits,
    output logic [27:0] raw,
    output logic [3:0]  dvalid,
    output logic [3:0]  seen,
    output logic        upd,
    output logic        frame,
    output logic        err_multi,
    output logic        stale
);

    localparam logic [2:0]    SET_C   = 3'(SETTLE);
    localparam logic [2:0]    SET_M1  = 3'(SETTLE - 1);
    localparam logic [TW-1:0] STALE_C = TW'(STALE);
    localparam logic [TW-1:0] STALE_1 = TW'(STALE - 1);

    logic [6:0]    seg_q;
    logic [3:0]    an_q;
    logic [2:0]    cnt;
    logic [TW-1:0] scnt;

    logic          same, acc, one_hot, multi, cap, stale_hit;
    logic          upd_nx, frame_nx;
    logic [3:0]    sel, seen_or, raw_chg;

    // Qualify the sampled pattern and classify the anode selects
    always_comb begin
        same      = (seg_in == seg_q) && (an_in == an_q);
        acc       = same && (cnt == SET_M1);
        sel       = ~an_q;
        one_hot   = (sel != 4'h0) && ((sel & (sel - 4'd1)) == 4'h0);
        multi     = (sel != 4'h0) && !one_hot;
        cap       = acc && one_hot;
        seen_or   = seen | sel;
        for (int n = 0; n < 4; n++)
            raw_chg[n] = (seg_q != raw[7*n +: 7]);
        upd_nx    = cap && ((sel & (raw_chg | ~seen)) != 4'h0);
        frame_nx  = cap && (seen_or == 4'hF);
        // scnt saturates at STALE, so STALE-1 is seen exactly once per timeout
        stale_hit = !cap && (scnt == STALE_1);
    end

    // Pin sampling and settle counter (saturation gives one accept per window)
    always_ff @(posedge CLK1) begin
        if (arst) begin
            seg_q <= 7'h7F;
            an_q  <= 4'hF;
            cnt   <= 3'd0;
        end else begin
            seg_q <= seg_in;
            an_q  <= an_in;
            if (!same)             cnt <= 3'd0;
            else if (cnt != SET_C) cnt <= cnt + 3'd1;
        end
    end

    // Round tracking, event pulses and stale timeout
    always_ff @(posedge CLK1) begin
        if (arst) begin
            seen      <= 4'h0;
            upd       <= 1'b0;
            frame     <= 1'b0;
            err_multi <= 1'b0;
            stale     <= 1'b0;
            scnt      <= '0;
        end else begin
            upd       <= upd_nx;
            frame     <= frame_nx;
            err_multi <= acc && multi;
            if (cap) begin
                seen  <= frame_nx ? 4'h0 : seen_or;
                scnt  <= '0;
                stale <= 1'b0;
            end else begin
                if (scnt != STALE_C) scnt <= scnt + TW'(1);
                if (stale_hit)       stale <= 1'b1;
            end
        end
    end

    for (genvar n = 0; n < 4; n++) begin : g_slot
        seg_scan_slot u_slot (
            .clk       (CLK1),
            .arst      (arst),
            .cap       (cap && sel[n]),
            .clr_valid (stale_hit),
            .seg       (seg_q),
            .raw       (raw[7*n +: 7]),
            .nib       (digits[4*n +: 4]),
            .dvalid    (dvalid[n])
        );
    end

endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Passive monitor for the board's multiplexed 4-digit seven-segment bus. It samples the same `seg`/`an` lines that the display drivers produce and qualifies each stable pattern. It decodes the pattern back to a hex nibble and keeps one capture slot per digit. It is the read-back end of the display interface, used for on-board loopback checking and self-test of the display drivers.

## Interface
- `SETTLE`, 4: consecutive equal samples (beyond the first) required before a pattern is accepted; legal range 1..7.
- `STALE`, 50_000_000: cycles without a digit capture before all `dvalid` bits drop (1 s at 50 MHz).
- `TW`, 26: stale counter width; must hold `STALE`.
- `CLK1` input, 1 bit: the single clock; all state changes on its rising edge.
- `arst` input, 1 bit: reset, synchronous and active-high.
- `seg_in` input, [0:6]: segment lines, active-low, `seg_in[0]`=a … `seg_in[6]`=g.
- `an_in` input, [3:0]: anode selects, active-low, bit n = digit n (digit 3 leftmost).
- `digits` output, 16 bits: decoded nibble per digit, digit n in [4n+3:4n].
- `raw` output, 28 bits: last accepted raw pattern per digit, digit n in [7n+6:7n], same bit order as `seg_in`.
- `dvalid` output, 4 bits: digit n's last capture matched a hex glyph.
- `seen` output, 4 bits: digit n captured in the current scan round.
- `upd` output, 1 bit: one-cycle pulse when a capture changes a slot's `raw` or fills a slot not yet `seen`.
- `frame` output, 1 bit: one-cycle pulse when a capture completes a round (all four seen).
- `err_multi` output, 1 bit: one-cycle pulse when an accepted `an` has two or more zeros.
- `stale` output, 1 bit: high from stale timeout until the next digit capture.

## Operation
- Sample registers `seg_q` and `an_q` load the pins every cycle.
- Settle counter `cnt`, 3 bits:
  - if the pins differ from `{seg_q, an_q}`, `cnt` <= 0;
  - otherwise `cnt` <= `cnt`+1, saturating at `SETTLE`.
- Accept fires when the pins equal the samples and `cnt`==`SETTLE`-1. Saturation guarantees exactly one accept per stable window.
- On accept, classify `an_q`:
  - `4'b1111` (blank): no capture and no pulse.
  - Exactly one zero at position n: capture into slot n.
  - Two or more zeros: `err_multi` pulses and no slot changes.
- Capture into slot n:
  - `raw` slot <= `seg_q`.
  - If `seg_q` matches a glyph, the nibble <= its value and `dvalid[n]` <= 1. Otherwise the nibble keeps its old value and `dvalid[n]` <= 0.
  - `upd` pulses if the new `raw` differs from the old one or `seen[n]` was 0.
  - `seen[n]` <= 1. If the result would be `4'b1111`, `frame` pulses and `seen` <= `4'b0000` on the same edge.
  - The stale counter clears to 0 and `stale` <= 0.
- Glyph table, `seg_in[0:6]` active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Stale counter:
  - increments every cycle without a capture, saturating at `STALE`;
  - on reaching `STALE`, `dvalid` <= `4'b0000` and `stale` <= 1;
  - `digits`, `raw` and `seen` are kept.
- Simultaneous capture and stale timeout on the same cycle: the capture wins. `stale` stays 0 and `dvalid` takes the capture result.

## Timing
- Reset values:
  - `digits` = 0, `raw` = 28'hFFFFFFF, `dvalid` = 0, `seen` = 0;
  - `upd`, `frame`, `err_multi`, `stale` = 0;
  - `seg_q` = 7'h7F, `an_q` = 4'hF, `cnt` = 0, stale counter = 0.
- Latency:
  - A pattern first present at edge e0 updates the outputs on edge e0+`SETTLE`.
  - A pattern held for fewer than `SETTLE`+1 edges is ignored.
- All outputs are registered. The pulses are high for exactly one cycle following the accepting edge.
- A steady pattern held indefinitely is accepted once. It is re-accepted only after the pins change and return.
- Reset mid-window discards the partial settle count. Reset asserted together with an accept: reset wins.

## Test plan
- Reset, then `an_in`=1110, `seg_in`=0010010 held 10 cycles, `SETTLE`=4:
  - `digits[3:0]`=2, `dvalid`=0001, `seen`=0001, `raw[6:0]`=0010010;
  - `upd` pulses once, on edge e0+4.
- Glitch: a pattern held only 3 edges between two blanks -> no capture and no pulse.
- Scan digits 0..3 with glyphs 1, 2, 3, 4, each held 8 cycles:
  - `digits`=16'h4321, `frame` pulses on the digit-3 capture, `seen` returns to 0000;
  - `upd` pulses 4 times; a repeat scan gives `upd` 0 pulses until the first capture of a new round.
- Upper-square pattern 0011100 on digit 3 -> `raw[27:21]`=0011100, `dvalid[3]`=0, `digits[15:12]` unchanged.
- `an_in`=0110 held -> one `err_multi` pulse; `seen` and `raw` unchanged.
- `STALE`=20, one capture, then blank held -> `stale`=1 and `dvalid`=0 on the 20th cycle after the capture; the next capture clears `stale`.
